// File: rtl/joybus_tx.sv
// joybus_tx: Joybus serial transmitter for the emulated N64 controller.
//
// A frame of 1..MAX_BYTES bytes is sent MSB first. Each bit is split into four
// quarters, and each quarter lasts LEVEL_WIDTH clocks. The frame ends with a
// console or controller stop bit. When the stop bit's released quarter has
// finished, the line is handed back to the receiver with a one-cycle pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      transmit request, sampled only while idle
//   num_bytes  frame length (0 = stop bit only, >MAX_BYTES clamps)
//   tx_data    payload, byte 0 in the top 8 bits, sent first
//   stop_mode  0 = console stop (L,H,H,Z), 1 = controller stop (L,L,H,Z)
//   line_low   1 = pull the open-drain line low, 0 = release
//   busy       high while a frame is in flight
//   rx_handoff one-cycle pulse when the line is released to the receiver
//
// State table
//   IDLE | line released, waiting for start
//   DATA | shifting payload bits out, quarter by quarter
//   STOP | sending the latched stop pattern
module joybus_tx #(
  parameter int LEVEL_WIDTH = 2,
  parameter int MAX_BYTES   = 4,
  parameter int LEN_W       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         num_bytes,
  input  logic [8*MAX_BYTES-1:0]   tx_data,
  input  logic                     stop_mode,
  output logic                     line_low,
  output logic                     busy,
  output logic                     rx_handoff
);

  localparam int DW    = 8 * MAX_BYTES;
  localparam int LVL_W = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e             state_q;
  logic [LVL_W-1:0]   lvl_q;
  logic [1:0]         qtr_q;
  logic [2:0]         bit_q;
  logic [LEN_W-1:0]   byte_q;
  logic [LEN_W-1:0]   n_eff_q;
  logic [DW-1:0]      data_q;
  logic               stop_mode_q;
  logic               line_low_q;
  logic               busy_q;
  logic               rx_handoff_q;

  logic               lvl_wrap;
  logic               qtr_wrap;
  logic               bit_wrap;
  logic               last_byte;
  logic [LVL_W-1:0]   lvl_d;
  logic [1:0]         qtr_d;
  logic               to_stop;
  logic               bit_val_d;
  logic               low_d;
  logic [LEN_W-1:0]   n_eff_d;

  // The counters always describe the quarter currently on the line. The
  // registered line level for the next cycle is therefore encoded from the
  // position the counters move to on this edge.
  always_comb begin
    lvl_wrap  = (lvl_q == LVL_W'(LEVEL_WIDTH - 1));
    qtr_wrap  = lvl_wrap && (qtr_q == 2'd3);
    bit_wrap  = qtr_wrap && (bit_q == 3'd7);
    last_byte = (byte_q == (n_eff_q - LEN_W'(1)));
    lvl_d     = lvl_wrap ? '0 : (lvl_q + LVL_W'(1));
    qtr_d     = lvl_wrap ? (qtr_q + 2'd1) : qtr_q;
    to_stop   = (state_q == STOP) || (bit_wrap && last_byte);
    // When a bit completes, the shift happens on this same edge, so the next
    // bit is the one just below the MSB.
    bit_val_d = qtr_wrap ? data_q[DW-2] : data_q[DW-1];
    low_d     = 1'b0;
    if (to_stop) begin
      low_d = stop_mode_q ? (qtr_d < 2'd2) : (qtr_d == 2'd0);
    end else begin
      low_d = bit_val_d ? (qtr_d == 2'd0) : (qtr_d != 2'd3);
    end
    n_eff_d = num_bytes;
    if (num_bytes > LEN_W'(MAX_BYTES)) begin
      n_eff_d = LEN_W'(MAX_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lvl_q        <= '0;
      qtr_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      n_eff_q      <= '0;
      data_q       <= '0;
      stop_mode_q  <= 1'b0;
      line_low_q   <= 1'b0;
      busy_q       <= 1'b0;
      rx_handoff_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rx_handoff_q <= 1'b0;
          line_low_q   <= 1'b0;
          busy_q       <= 1'b0;
          if (start) begin
            lvl_q       <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            n_eff_q     <= n_eff_d;
            data_q      <= tx_data;
            stop_mode_q <= stop_mode;
            busy_q      <= 1'b1;
            // Every encoding, stop bits included, opens with an L quarter.
            line_low_q  <= 1'b1;
            state_q     <= (num_bytes == '0) ? STOP : DATA;
          end
        end

        DATA: begin
          lvl_q      <= lvl_d;
          qtr_q      <= qtr_d;
          line_low_q <= low_d;
          if (qtr_wrap) begin
            bit_q  <= bit_q + 3'd1;
            data_q <= data_q << 1;
          end
          if (bit_wrap) begin
            if (last_byte) begin
              state_q <= STOP;
            end else begin
              byte_q <= byte_q + LEN_W'(1);
            end
          end
        end

        STOP: begin
          lvl_q <= lvl_d;
          qtr_q <= qtr_d;
          if (qtr_wrap) begin
            state_q      <= IDLE;
            line_low_q   <= 1'b0;
            busy_q       <= 1'b0;
            rx_handoff_q <= 1'b1;
          end else begin
            line_low_q <= low_d;
          end
        end

        default: begin
          state_q    <= IDLE;
          line_low_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign line_low   = line_low_q;
  assign busy       = busy_q;
  assign rx_handoff = rx_handoff_q;

endmodule
